// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port on-chip RAM (registered address, 1-cycle read latency).
// Build option: define ONCHIP_ARB_FIXED_PRIO_EN to make m0 win every tie instead of round robin.
module onchip_mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    output logic                m0_waitrequest,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic                m1_waitrequest,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                mem_clken
);

    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;
    logic granted;
    logic tie_pick;    // index that wins when both masters request
    logic last_grant;  // index of the most recently granted master
    logic sel;         // command mux select
    logic rd_pend;
    logic rd_owner;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef ONCHIP_ARB_FIXED_PRIO_EN
    assign tie_pick = 1'b0;
`else
    assign tie_pick = ~last_grant;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                gnt0 = ~tie_pick;
                gnt1 = tie_pick;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign granted = gnt0 | gnt1;
    // With no grant the mux parks on the last owner so the RAM inputs stay quiet.
    assign sel     = granted ? gnt1 : last_grant;

    always_comb begin
        if (sel) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
        end else begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
        end
    end

    // Read+write from one master issues as a write and produces no read strobe.
    assign mem_chipselect = granted;
    assign mem_write      = granted & (sel ? m1_write : m0_write);
    assign mem_clken      = 1'b1;

    assign m0_waitrequest = ~gnt0;
    assign m1_waitrequest = ~gnt1;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            last_grant <= 1'b1;
            rd_pend    <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            if (granted) begin
                last_grant <= gnt1;
            end
            rd_pend  <= granted & ~mem_write;
            rd_owner <= sel;
        end
    end

    // Gated by reset so a read accepted just before reset never reports data.
    assign m0_readdatavalid = rd_pend & ~rd_owner & ~reset;
    assign m1_readdatavalid = rd_pend &  rd_owner & ~reset;

    assign m0_readdata = mem_readdata;
    assign m1_readdata = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: behavioural RAM, a per-cycle scoreboard model, and directed scenarios.
module tb_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        m0_waitrequest, m1_waitrequest;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    int n_checks = 0;
    int n_pass   = 0;

    onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid), .m1_waitrequest(m1_waitrequest),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_clken(mem_clken)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A000000 ^ (i * 32'h00010203);
    endfunction

    // RAM model: address registered, q unregistered, byte-lane writes.
    logic [31:0] ram [0:1023];
    logic [9:0]  addr_q = '0;

    initial for (int i = 0; i < 1024; i++) ram[i] = init_word(i);

    always @(posedge clk) begin
        if (mem_clken) begin
            if (mem_chipselect && mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            addr_q <= mem_address;
        end
    end
    assign mem_readdata = ram[addr_q];

    // Scoreboard: who should win this cycle, and what each master should see next cycle.
    logic [31:0] shadow [0:1023];
    int          last_win  = 1;
    int          pend_to   = -1;
    logic [31:0] pend_data = '0;

    initial for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);

    always @(negedge clk) begin
        int          win;
        logic        r0, r1, w_wr;
        logic [9:0]  w_addr;
        logic [3:0]  w_be;
        logic [31:0] w_data;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        if (reset)          win = -1;
        else if (r0 && r1) begin
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
            win = 0;
`else
            win = (last_win == 0) ? 1 : 0;
`endif
        end
        else if (r0)        win = 0;
        else if (r1)        win = 1;
        else                win = -1;

        w_wr   = (win == 1) ? m1_write     : m0_write;
        w_addr = (win == 1) ? m1_address   : m0_address;
        w_be   = (win == 1) ? m1_byteenable : m0_byteenable;
        w_data = (win == 1) ? m1_writedata : m0_writedata;

        check("m0_waitrequest", m0_waitrequest, win != 0);
        check("m1_waitrequest", m1_waitrequest, win != 1);
        check("mem_chipselect", mem_chipselect, win >= 0);
        check("mem_write", mem_write, (win >= 0) && w_wr);
        check("mem_clken", mem_clken, 1'b1);
        check("m0_readdatavalid", m0_readdatavalid, !reset && pend_to == 0);
        check("m1_readdatavalid", m1_readdatavalid, !reset && pend_to == 1);
        if (!reset && pend_to == 0) check("m0_readdata", m0_readdata, pend_data);
        if (!reset && pend_to == 1) check("m1_readdata", m1_readdata, pend_data);
        if (win >= 0) begin
            check("mem_address", 32'(mem_address), 32'(w_addr));
            check("mem_byteenable", 32'(mem_byteenable), 32'(w_be));
            if (w_wr) check("mem_writedata", mem_writedata, w_data);
        end

        pend_to = -1;
        if (reset) begin
            last_win = 1;
        end else if (win >= 0) begin
            last_win = win;
            if (w_wr) begin
                for (int b = 0; b < 4; b++)
                    if (w_be[b]) shadow[w_addr][8*b +: 8] = w_data[8*b +: 8];
            end else begin
                pend_to   = win;
                pend_data = shadow[w_addr];
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = 4'hF; m0_writedata = '0;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = 4'hF; m1_writedata = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle();

        // Reset held with m0 requesting: nothing reaches the RAM.
        m0_read = 1; m0_address = 10'h010;
        repeat (3) begin
            at_sample();
            check("t1_m0_waitrequest", m0_waitrequest, 1'b1);
            check("t1_mem_chipselect", mem_chipselect, 1'b0);
            check("t1_m0_readdatavalid", m0_readdatavalid, 1'b0);
            next_cycle();
        end
        reset = 1'b0;
        idle();
        next_cycle();

        // Write then read the same word on consecutive cycles.
        m0_write = 1; m0_address = 10'h010; m0_writedata = 32'hDEADBEEF;
        at_sample();
        check("t2_wr_accept", m0_waitrequest, 1'b0);
        next_cycle();
        m0_write = 0; m0_read = 1;
        at_sample();
        check("t2_rd_accept", m0_waitrequest, 1'b0);
        next_cycle();
        idle();
        at_sample();
        check("t2_rdv", m0_readdatavalid, 1'b1);
        check("t2_rdata", m0_readdata, 32'hDEADBEEF);
        next_cycle();

        // m1 single read leaves last grant on m1, so the contention run starts with m0.
        m1_read = 1; m1_address = 10'h040;
        next_cycle();
        m0_read = 1; m0_address = 10'h020;
        for (int k = 0; k < 8; k++) begin
            at_sample();
            check("t3_m0_wait", m0_waitrequest, (k % 2) == 1);
            check("t3_m1_wait", m1_waitrequest, (k % 2) == 0);
            if (k >= 1) check("t3_m0_rdv", m0_readdatavalid, (k % 2) == 1);
            next_cycle();
        end
        idle();
        at_sample();
        check("t3_last_m1_rdv", m1_readdatavalid, 1'b1);
        next_cycle();

        // Partial byte-lane write over an all-ones word.
        m1_write = 1; m1_address = 10'h3FF; m1_writedata = 32'hFFFFFFFF; m1_byteenable = 4'hF;
        next_cycle();
        m1_writedata = 32'h11223344; m1_byteenable = 4'b0101;
        next_cycle();
        m1_write = 0; m1_read = 1; m1_byteenable = 4'hF;
        next_cycle();
        idle();
        at_sample();
        check("t4_rdv", m1_readdatavalid, 1'b1);
        check("t4_rdata", m1_readdata, 32'hFF22FF44);
        next_cycle();

        // Read accepted, then reset: no strobe, and the first tie afterwards goes to m0.
        m0_read = 1; m0_address = 10'h010;
        at_sample();
        check("t5_accept", m0_waitrequest, 1'b0);
        next_cycle();
        reset = 1'b1;
        idle();
        repeat (2) begin
            at_sample();
            check("t5_rdv_in_reset", m0_readdatavalid, 1'b0);
            check("t5_no_write", mem_write, 1'b0);
            next_cycle();
        end
        reset = 1'b0;
        m0_read = 1; m1_read = 1; m0_address = 10'h011; m1_address = 10'h012;
        at_sample();
        check("t5_tie_m0", m0_waitrequest, 1'b0);
        check("t5_tie_m1", m1_waitrequest, 1'b1);
        next_cycle();

        // Four cycles of contention: m0 writing, m1 reading the same word.
        m0_read = 0; m0_write = 1; m0_address = 10'h100;
        m1_read = 1; m1_address = 10'h100;
        for (int k = 0; k < 4; k++) begin
            m0_writedata = 32'hA0000000 + 32'(k);
            at_sample();
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
            check("t6_m1_wait", m1_waitrequest, 1'b1);
            check("t6_m0_wait", m0_waitrequest, 1'b0);
`else
            check("t6_m1_wait", m1_waitrequest, (k % 2) == 1);
`endif
            next_cycle();
        end
        idle();
        next_cycle();

        // Read and write together from one master: a write with no read strobe.
        m0_read = 1; m0_write = 1; m0_address = 10'h200; m0_writedata = 32'hCAFEF00D;
        at_sample();
        check("t7_is_write", mem_write, 1'b1);
        next_cycle();
        idle();
        at_sample();
        check("t7_no_rdv", m0_readdatavalid, 1'b0);
        next_cycle();
        m0_read = 1; m0_address = 10'h200;
        next_cycle();
        idle();
        at_sample();
        check("t7_rdata", m0_readdata, 32'hCAFEF00D);
        next_cycle();

        repeat (3) next_cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
